// File: rtl/glip_pkg.sv
// Shared GLIP definitions: link word type, link width, packer state
// decode and the slot-to-bit-position helper used by the packer.
package glip_pkg;

   localparam int unsigned GLIP_WORD_WIDTH = 16;

   typedef logic [GLIP_WORD_WIDTH-1:0] glip_word_t;

   // Packer fill state, decoded from the beat counter: LAST means the next
   // accepted beat completes a word.
   typedef enum logic {
      ST_FILL = 1'b0,
      ST_LAST = 1'b1
   } fill_state_t;

   // Lowest bit index of accumulator slot 'slot'. With msb_first set, slot 0
   // sits in the top IN_WIDTH bits of the packed word.
   function automatic int unsigned slot_lsb(input int unsigned slot,
                                            input int unsigned factor,
                                            input int unsigned width,
                                            input bit          msb_first);
      if (msb_first)
         return (factor - 1 - slot) * width;
      else
         return slot * width;
   endfunction

endpackage

// File: rtl/glip_channel_if.sv
// GLIP valid/ready channel bundle. The master drives data/valid and the
// slave drives ready; a transfer happens when valid & ready in one cycle.
interface glip_channel #(
   parameter int unsigned WIDTH = 16
) ();

   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/glip_out_reg.sv
// Single-entry registered valid/ready output stage. A load replaces the held
// word and keeps valid high even if the previous word is accepted on the same
// edge, so back-to-back words flow without a bubble.
module glip_out_reg #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_partial,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_partial,
   output logic             out_free
);

   // Stage can take a new word when empty or when its word leaves this cycle.
   always_comb begin
      out_free = !out_valid || out_ready;
   end

   // Load/accept/hold of the registered output word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_partial <= 1'b0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_data    <= load_data;
         out_partial <= load_partial;
      end else if (out_valid && out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/glip_channel_rx_packer.sv
// Receive end of a GLIP channel: packs FACTOR consecutive IN_WIDTH beats
// into one wide word offered on a registered master channel. A flush pulse
// emits the partially filled word zero-padded and marked partial.
module glip_channel_rx_packer
   import glip_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = GLIP_WORD_WIDTH,
   parameter int unsigned FACTOR    = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   glip_channel.slave                in_ch,
   glip_channel.master               out_ch,
   input  logic                      flush,
   output logic                      out_partial,
   output logic [$clog2(FACTOR)-1:0] beat_cnt
);

   localparam int unsigned OUT_WIDTH = IN_WIDTH * FACTOR;
   localparam int unsigned CNT_W     = $clog2(FACTOR);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FACTOR - 1);

   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 out_ready;
   logic                 out_valid;
   logic                 out_free;
   logic [OUT_WIDTH-1:0] out_data;
   logic [OUT_WIDTH-1:0] acc_q;
   logic [OUT_WIDTH-1:0] acc_next;
   fill_state_t          state;
   logic                 beat_acc;
   logic                 complete;
   logic                 do_flush;
   logic                 load;

   assign in_data      = in_ch.data;
   assign in_valid     = in_ch.valid;
   assign in_ch.ready  = in_ready;
   assign out_ready    = out_ch.ready;
   assign out_ch.valid = out_valid;
   assign out_ch.data  = out_data;

   // Handshake and word-completion decode. A pending flush that cannot be
   // honoured yet also blocks input so the caller can hold flush without a
   // beat slipping in ahead of the flushed word.
   always_comb begin
      state    = (beat_cnt == CNT_LAST) ? ST_LAST : ST_FILL;
      in_ready = !rst && ((state != ST_LAST) || out_free) && !(flush && !out_free);
      beat_acc = in_valid && in_ready;
      complete = beat_acc && (state == ST_LAST);
      do_flush = flush && out_free && ((beat_cnt != '0) || beat_acc);
      load     = complete || do_flush;
   end

   // Accumulator image including a beat accepted this cycle, so a completing
   // beat or a same-cycle flush loads the word straight into the output stage.
   always_comb begin
      acc_next = acc_q;
      for (int unsigned k = 0; k < FACTOR; k++) begin
         if (beat_acc && (beat_cnt == CNT_W'(k)))
            acc_next[slot_lsb(k, FACTOR, IN_WIDTH, MSB_FIRST) +: IN_WIDTH] = in_data;
      end
   end

   // Beat counter and accumulator; both clear whenever a word is emitted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         acc_q    <= '0;
      end else if (load) begin
         beat_cnt <= '0;
         acc_q    <= '0;
      end else if (beat_acc) begin
         beat_cnt <= beat_cnt + 1'b1;
         acc_q    <= acc_next;
      end
   end

   glip_out_reg #(
      .WIDTH (OUT_WIDTH)
   ) u_out_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .load_data    (acc_next),
      .load_partial (!complete),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_partial  (out_partial),
      .out_free     (out_free)
   );

endmodule
